// File: rtl/mult2x2_pipe.sv
// Unsigned 2x2 multiplier with a gate-level partial-product array
// and a configurable valid-tagged output pipeline (LATENCY 0..3).

module mult2x2_array (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] y
);

    logic p00;
    logic p01;
    logic p10;
    logic p11;
    logic c1;

    assign p00 = a[0] & b[0];
    assign p01 = a[0] & b[1];
    assign p10 = a[1] & b[0];
    assign p11 = a[1] & b[1];

    // two half adders reduce the middle and top columns
    assign c1   = p10 & p01;
    assign y[0] = p00;
    assign y[1] = p10 ^ p01;
    assign y[2] = p11 ^ c1;
    assign y[3] = p11 & c1;

endmodule

module mult2x2_pipe #(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [3:0] Y,
    output logic       out_valid
);

    logic [3:0] prod_c;

    mult2x2_array u_array (
        .a (A),
        .b (B),
        .y (prod_c)
    );

    generate
        if (LATENCY < 0 || LATENCY > 3) begin : g_bad
            $error("mult2x2_pipe: LATENCY must be in 0..3");
        end else if (LATENCY == 0) begin : g_comb
            assign Y         = prod_c;
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_q;
            logic [3:0]         prd_q [LATENCY];

            // shift valid every cycle; a product only advances behind a valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int k = 0; k < LATENCY; k++) begin
                        prd_q[k] <= 4'h0;
                    end
                end else begin
                    vld_q[0] <= in_valid;
                    if (in_valid) begin
                        prd_q[0] <= prod_c;
                    end
                    for (int k = 1; k < LATENCY; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        if (vld_q[k-1]) begin
                            prd_q[k] <= prd_q[k-1];
                        end
                    end
                end
            end

            assign Y         = prd_q[LATENCY-1];
            assign out_valid = vld_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_mult2x2_pipe.sv
// Directed bench for mult2x2_pipe at LATENCY 0..3 with a
// history-based reference model checked on every falling edge.

module tb_mult2x2_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] A;
    logic [1:0] B;

    logic [3:0] y  [4];
    logic       ov [4];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         v;
        logic [3:0] p;
    } smp_t;

    smp_t hist[$];

    always #5 clk = ~clk;

    mult2x2_pipe #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Y(y[0]), .out_valid(ov[0])
    );
    mult2x2_pipe #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Y(y[1]), .out_valid(ov[1])
    );
    mult2x2_pipe #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Y(y[2]), .out_valid(ov[2])
    );
    mult2x2_pipe #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Y(y[3]), .out_valid(ov[3])
    );

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // model: every sampled pair since reset; stage N shows entry len-N
    function automatic void model(input int n, output bit ev,
                                  output logic [3:0] ey);
        int len;
        len = hist.size();
        ev  = 1'b0;
        ey  = 4'h0;
        for (int i = 0; i <= len - n; i++) begin
            if (hist[i].v) ey = hist[i].p;
        end
        if (len >= n) ev = hist[len-n].v;
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            hist.push_back('{v: (in_valid === 1'b1), p: 4'(A * B)});
        end
    end

    always @(negedge rst_n) hist.delete();

    always @(negedge clk) begin
        bit         ev;
        logic [3:0] ey;
        if (!$isunknown({A, B})) begin
            chk("l0_y", y[0], 4'(A * B));
        end
        chk("l0_valid", {3'b0, ov[0]}, {3'b0, in_valid});
        for (int n = 1; n < 4; n++) begin
            model(n, ev, ey);
            chk($sformatf("l%0d_y", n), y[n], ey);
            chk($sformatf("l%0d_valid", n), {3'b0, ov[n]}, {3'b0, ev});
        end
    end

    task automatic cyc(input logic v, input logic [1:0] a,
                       input logic [1:0] b);
        @(negedge clk);
        #2;
        in_valid = v;
        A        = a;
        B        = b;
    endtask

    task automatic spot(input logic [1:0] a, input logic [1:0] b,
                        input logic [3:0] exp);
        A = a;
        B = b;
        #2;
        chk($sformatf("spot_%0dx%0d", a, b), y[0], exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 2'd0;
        B        = 2'd0;

        repeat (2) @(negedge clk);
        #1;
        for (int n = 1; n < 4; n++) begin
            chk($sformatf("rst_y%0d", n), y[n], 4'h0);
            chk($sformatf("rst_v%0d", n), {3'b0, ov[n]}, 4'h0);
        end

        for (int i = 0; i < 16; i++) begin
            A = 2'(i >> 2);
            B = 2'(i);
            #2;
            chk("l0_exh", y[0], 4'((i >> 2) * (i & 3)));
        end
        spot(2'd0, 2'd3, 4'd0);
        spot(2'd1, 2'd3, 4'd3);
        spot(2'd2, 2'd2, 4'd4);
        spot(2'd3, 2'd2, 4'd6);
        spot(2'd3, 2'd3, 4'd9);

        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 2'(i >> 2), 2'(i));
            if (i > 0) begin
                chk("stream_y", y[1], 4'(((i - 1) >> 2) * ((i - 1) & 3)));
                chk("stream_v", {3'b0, ov[1]}, 4'h1);
            end
        end
        cyc(1'b1, 2'd1, 2'd2);
        chk("stream_last", y[1], 4'd9);

        cyc(1'b1, 2'd3, 2'd3);
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("bub_y0", y[2], 4'd9);
        chk("bub_v0", {3'b0, ov[2]}, 4'h1);
        cyc(1'b1, 2'd2, 2'd3);
        chk("bub_y1", y[2], 4'd9);
        chk("bub_v1", {3'b0, ov[2]}, 4'h0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("bub_y2", y[2], 4'd9);
        chk("bub_v2", {3'b0, ov[2]}, 4'h0);
        cyc(1'b0, 2'd0, 2'd0);
        chk("bub_y3", y[2], 4'd6);
        chk("bub_v3", {3'b0, ov[2]}, 4'h1);

        cyc(1'b1, 2'd2, 2'd2);
        cyc(1'b1, 2'd2, 2'd2);
        cyc(1'b1, 2'd2, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        for (int n = 1; n < 4; n++) begin
            chk($sformatf("async_y%0d", n), y[n], 4'h0);
            chk($sformatf("async_v%0d", n), {3'b0, ov[n]}, 4'h0);
        end
        cyc(1'b1, 2'd3, 2'd2);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 2'd0, 2'd0);
        chk("rel_y", y[1], 4'd6);
        chk("rel_v", {3'b0, ov[1]}, 4'h1);

        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b1, 2'd3, 2'd1);
        cyc(1'b1, 2'd2, 2'd1);
        cyc(1'b0, 2'd0, 2'd0);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'd0, 2'd0);
            chk("flush_v", {3'b0, ov[3]}, 4'h0);
            chk("flush_y", y[3], 4'h0);
        end

        cyc(1'b1, 2'd3, 2'd2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'bxx, 2'bxx);
        end
        for (int n = 1; n < 4; n++) begin
            chk($sformatf("x_y%0d", n), y[n], 4'd6);
            chk($sformatf("x_v%0d", n), {3'b0, ov[n]}, 4'h0);
        end
        cyc(1'b0, 2'd0, 2'd0);
        cyc(1'b0, 2'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
